// File: rtl/readout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : readout_pkg
//  Description : Shared constants for the sample read-out stage: FSM state
//                encoding, stream header magic byte, and the default sample
//                RAM geometry shared with the acquisition stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package readout_pkg;

    // Sample RAM geometry, common to acquisition and read-out.
    localparam int c_ram_size   = 1536;
    localparam int c_addr_width = 11;

    // First byte of the optional stream header.
    localparam logic [7:0] c_hdr_magic = 8'hA5;

    // Read-out FSM state encoding.
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_wait  = 3'd1;
    localparam logic [2:0] c_st_latch = 3'd2;
    localparam logic [2:0] c_st_send  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;
    localparam logic [2:0] c_st_hdr0  = 3'd5;
    localparam logic [2:0] c_st_hdr1  = 3'd6;

endpackage : readout_pkg
`default_nettype wire

// File: rtl/readout.sv
`default_nettype none
// ============================================================================
//  Module      : readout
//  Description : Walks the sample RAM from address 0 to RAM_SIZE-1 once the
//                arbiter grants the read phase and streams every sample to
//                the host transmitter over a valid/ready byte interface.
//                Optional macro READOUT_HEADER_EN prefixes the stream with
//                the magic byte A5 and the low byte of RAM_SIZE.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                grant_rd       - read-phase grant (level)
//                done_rd        - high while the read-out is complete
//                rd_addr/rd_en  - RAM read port request (registered)
//                rd_data        - RAM data, one cycle after rd_en
//                tx_data/tx_valid/tx_ready - byte stream to the transmitter
//  Revision    : 1.0 - initial release
// ============================================================================
module readout
    import readout_pkg::*;
#(
    parameter int RAM_SIZE   = c_ram_size,
    parameter int ADDR_WIDTH = c_addr_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  grant_rd,
    output logic                  done_rd,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [7:0]            rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(RAM_SIZE - 1);
`ifdef READOUT_HEADER_EN
    localparam logic [7:0] c_size_lo = 8'(RAM_SIZE);
`endif

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_en;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_done_rd;
    logic [15:0]           r_sample_cnt;

    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_addr_nxt;
    logic                  w_rd_en_nxt;
    logic [7:0]            w_tx_data_nxt;
    logic                  w_tx_valid_nxt;
    logic                  w_done_rd_nxt;
    logic [15:0]           w_sample_cnt_nxt;
    logic                  w_hs;

    // tx_ready only matters while a byte is offered.
    assign w_hs = r_tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_rd_addr    <= '0;
            r_rd_en      <= 1'b0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_done_rd    <= 1'b0;
            r_sample_cnt <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_done_rd    <= w_done_rd_nxt;
            r_sample_cnt <= w_sample_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rd_addr_nxt    = r_rd_addr;
        w_rd_en_nxt      = 1'b0;           // read enable is a single-cycle pulse
        w_tx_data_nxt    = r_tx_data;
        w_tx_valid_nxt   = r_tx_valid;
        w_done_rd_nxt    = r_done_rd;
        w_sample_cnt_nxt = r_sample_cnt;

        case (r_state)
            c_st_idle: begin
                if (grant_rd) begin
                    w_sample_cnt_nxt = 16'h0000;
`ifdef READOUT_HEADER_EN
                    w_tx_data_nxt  = c_hdr_magic;
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = c_st_hdr0;
`else
                    w_rd_addr_nxt  = '0;
                    w_rd_en_nxt    = 1'b1;
                    w_state_nxt    = c_st_wait;
`endif
                end
            end

            c_st_wait: begin
                // RAM registers the read on this edge; data is usable next cycle.
                if (!grant_rd) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = c_st_idle;
                end else begin
                    w_state_nxt    = c_st_latch;
                end
            end

            c_st_latch: begin
                if (!grant_rd) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = c_st_idle;
                end else begin
                    w_tx_data_nxt  = rd_data;
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = c_st_send;
                end
            end

            c_st_send: begin
                // A handshake on the revoking edge is still a delivered sample.
                if (w_hs) begin
                    w_sample_cnt_nxt = r_sample_cnt + 16'd1;
                end
                if (!grant_rd) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = c_st_idle;
                end else if (w_hs) begin
                    w_tx_valid_nxt = 1'b0;
                    if (r_rd_addr == c_last_addr) begin
                        w_done_rd_nxt = 1'b1;
                        w_state_nxt   = c_st_done;
                    end else begin
                        w_rd_addr_nxt = r_rd_addr + 1'b1;
                        w_rd_en_nxt   = 1'b1;
                        w_state_nxt   = c_st_wait;
                    end
                end
            end

            c_st_done: begin
                // Hold completion until the arbiter withdraws the grant.
                if (!grant_rd) begin
                    w_done_rd_nxt = 1'b0;
                    w_state_nxt   = c_st_idle;
                end
            end

`ifdef READOUT_HEADER_EN
            c_st_hdr0: begin
                if (!grant_rd) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = c_st_idle;
                end else if (w_hs) begin
                    w_tx_data_nxt  = c_size_lo;
                    w_state_nxt    = c_st_hdr1;
                end
            end

            c_st_hdr1: begin
                if (!grant_rd) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = c_st_idle;
                end else if (w_hs) begin
                    w_tx_valid_nxt = 1'b0;
                    w_rd_addr_nxt  = '0;
                    w_rd_en_nxt    = 1'b1;
                    w_state_nxt    = c_st_wait;
                end
            end
`endif

            default: begin
                w_tx_valid_nxt = 1'b0;
                w_done_rd_nxt  = 1'b0;
                w_state_nxt    = c_st_idle;
            end
        endcase
    end

    assign done_rd  = r_done_rd;
    assign rd_addr  = r_rd_addr;
    assign rd_en    = r_rd_en;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule : readout
`default_nettype wire

// File: tb/tb_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_readout
//  Description : Scoreboard bench for readout. Stimulus pushes the expected
//                byte stream into a queue; a monitor pops and compares on
//                every tx handshake. RAM model: mem[i] = i[7:0] ^ 8'h3C.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_readout;

    localparam int RAM_SIZE   = 1536;
    localparam int ADDR_WIDTH = 11;
`ifdef READOUT_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int N_BYTES = RAM_SIZE + HDR;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  grant_rd = 1'b0;
    logic                  done_rd;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic [7:0]            rd_data = 8'h00;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready = 1'b1;

    readout #(
        .RAM_SIZE   (RAM_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .grant_rd (grant_rd),
        .done_rd  (done_rd),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int rx_count = 0;
    int cyc = 0;
    int last_hs_edge = 0;
    int max_addr = 0;
    int rd_en_cnt = 0;
    logic rnd_mode = 1'b0;
    logic ready_level = 1'b1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    function automatic logic [7:0] mem_val(input int i);
        logic [31:0] v;
        v = i;
        return v[7:0] ^ 8'h3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Synchronous-read RAM, one cycle latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem_val(int'(rd_addr));
    end

    always @(posedge clk) cyc <= cyc + 1;

    // tx_ready driver: #2 after the edge so stimulus changes at #1 apply the same cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_mode) tx_ready = ($urandom_range(0, 9) < 3);
            else          tx_ready = ready_level;
        end
    end

    // Monitor: samples on the falling edge, ahead of the edge that performs the transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (rd_en) rd_en_cnt++;
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
                if (prev_stall && tx_valid) check("stall_hold_data", tx_data, prev_data);
                if (tx_valid && tx_ready) begin
                    rx_count++;
                    last_hs_edge = cyc + 1;
                    if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
                    else                   check("stream_byte", tx_data, exp_q.pop_front());
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_stream();
`ifdef READOUT_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(RAM_SIZE));
`endif
        for (int i = 0; i < RAM_SIZE; i++) exp_q.push_back(mem_val(i));
    endtask

    // Counts edges from the one that samples the grant (inclusive) to the first tx_valid.
    task automatic start_and_latency(input string name);
        int k;
        grant_rd = 1'b1;
        k = 0;
        for (int j = 1; j <= 8; j++) begin
            step(1);
            if (tx_valid) begin
                k = j;
                break;
            end
        end
        check({name, "_first_valid_edges"}, k, (HDR != 0) ? 1 : 3);
        check({name, "_start_addr"}, rd_addr, 0);
    endtask

    task automatic wait_done(input string name);
        int ok;
        ok = 0;
        for (int j = 0; j < 40000; j++) begin
            step(1);
            if (done_rd) begin
                ok = 1;
                break;
            end
        end
        check({name, "_done_seen"}, ok, 1);
        if (ok == 1) check({name, "_done_edge"}, cyc, last_hs_edge);
        check({name, "_byte_count"}, rx_count, N_BYTES);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_max_addr"}, max_addr, RAM_SIZE - 1);
    endtask

    task automatic wait_rx(input string name, input int target);
        for (int j = 0; j < 20000; j++) begin
            if (rx_count >= target) break;
            step(1);
        end
        check({name, "_reached"}, (rx_count >= target) ? 1 : 0, 1);
    endtask

    initial begin
        int rd0;
        int bad;

        // Reset state.
        step(3);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_done_rd", done_rd, 0);
        rst = 1'b0;
        step(1);

        // Full read-out with the transmitter always ready.
        push_stream();
        rx_count = 0; max_addr = 0;
        start_and_latency("full");
        wait_done("full");

        // Grant held after completion: done stays, no new reads.
        rd0 = rd_en_cnt; bad = 0;
        for (int j = 0; j < 20; j++) begin
            step(1);
            if (!done_rd) bad++;
        end
        check("done_hold_low_cycles", bad, 0);
        check("done_hold_reads", rd_en_cnt - rd0, 0);
        grant_rd = 1'b0;
        step(1);
        check("done_release", done_rd, 0);
        step(2);

        // Full read-out under random backpressure.
        rnd_mode = 1'b1;
        push_stream();
        rx_count = 0; max_addr = 0;
        start_and_latency("bp");
        wait_done("bp");
        grant_rd = 1'b0;
        rnd_mode = 1'b0;
        ready_level = 1'b1;
        step(3);

        // Grant revoked while sample 100 waits in SEND.
        push_stream();
        rx_count = 0; max_addr = 0;
        start_and_latency("drop");
        wait_rx("drop_rx100", 100 + HDR);
        ready_level = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (tx_valid) break;
            step(1);
        end
        check("drop_in_send_valid", tx_valid, 1);
        grant_rd = 1'b0;
        step(1);
        check("drop_tx_valid", tx_valid, 0);
        rd0 = rd_en_cnt; bad = 0;
        for (int j = 0; j < 10; j++) begin
            step(1);
            if (done_rd) bad++;
        end
        check("drop_reads_after", rd_en_cnt - rd0, 0);
        check("drop_done_cycles", bad, 0);
        check("drop_byte_count", rx_count, 100 + HDR);
        exp_q.delete();
        ready_level = 1'b1;

        // Re-grant restarts at address 0; reset pulse at sample 500.
        push_stream();
        rx_count = 0; max_addr = 0;
        start_and_latency("regrant");
        wait_rx("regrant_rx500", 500 + HDR);
        rst = 1'b1;
        step(1);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_done_rd", done_rd, 0);
        exp_q.delete();
        push_stream();
        rx_count = 0; max_addr = 0;
        rst = 1'b0;
        start_and_latency("post_rst");
        wait_done("post_rst");
        grant_rd = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_readout
`default_nettype wire
